psum_add_arbiter: RTL

//   Shares one signed adder between N_REQ partial-sum requesters in the systolic MAC array.

---
 rtl/psum_arb_pkg.sv | 33 +++
 rtl/psum_add_arbiter_rr_arbiter.sv | 32 +++
 rtl/psum_add_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/psum_arb_pkg.sv
// Shared types and helpers for the partial-sum adder arbiter: width helpers,
// saturation bounds and the stage-1 operand payload.
package psum_arb_pkg;

  localparam int MAX_W = 64;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic logic signed [MAX_W:0] sat_max(input int w);
    return (65'sd1 <<< (w - 1)) - 65'sd1;
  endfunction

  function automatic logic signed [MAX_W:0] sat_min(input int w);
    return -(65'sd1 <<< (w - 1));
  endfunction

  // Operands are held sign-extended to a common width so any IN1/IN2 up to 63 bits fits.
  typedef struct packed {
    logic signed [MAX_W-1:0] a;
    logic signed [MAX_W-1:0] b;
  } s1_payload_t;

endpackage

// File: rtl/psum_add_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping.
// Produces a one-hot grant and its index; the pointer state lives in the parent.
module rr_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [N_REQ-1:0]    req,
  input  logic                en,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [N_REQ-1:0]    grant,
  output logic [ID_WIDTH-1:0] grant_idx
);

  logic found;
  int   j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr) + k) % N_REQ;
      if (en && !found && req[j]) begin
        grant[j]  = 1'b1;
        grant_idx = ID_WIDTH'(j);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/psum_add_arbiter.sv
// Shared signed adder with round-robin operand arbitration and a 2-stage pipeline.
// Define PSUM_SAT_EN to clamp out-of-range sums and flag them on rsp_sat.
module psum_add_arbiter
  import psum_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int IN1_WIDTH = 20,
  parameter int IN2_WIDTH = 32,
  parameter int OUT_WIDTH = 32,
  localparam int ID_WIDTH = clog2(N_REQ)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [N_REQ-1:0]               req_valid,
  output logic [N_REQ-1:0]               req_ready,
  input  logic [N_REQ*IN1_WIDTH-1:0]     req_a,
  input  logic [N_REQ*IN2_WIDTH-1:0]     req_b,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [ID_WIDTH-1:0]            rsp_id,
  output logic signed [OUT_WIDTH-1:0]    rsp_sum,
  output logic                           rsp_sat,
  output logic                           busy
);

  logic                        vld_p1, vld_p2;
  s1_payload_t                 pay_p1;
  logic [ID_WIDTH-1:0]         id_p1, id_p2;
  logic signed [OUT_WIDTH-1:0] sum_p2;
  logic signed [OUT_WIDTH-1:0] sum_d;
  logic [ID_WIDTH-1:0]         rr_ptr, rr_next;
  logic [N_REQ-1:0]            grant;
  logic [ID_WIDTH-1:0]         grant_idx;
  logic                        s1_adv, s2_adv;
  logic signed [IN1_WIDTH-1:0] a_sel;
  logic signed [IN2_WIDTH-1:0] b_sel;

  function automatic logic signed [OUT_WIDTH-1:0] wrap_sum(input s1_payload_t p);
    return OUT_WIDTH'(p.a + p.b);
  endfunction

`ifdef PSUM_SAT_EN
  logic sat_d, sat_p2;

  function automatic logic [OUT_WIDTH:0] sat_sum(input s1_payload_t p);
    logic signed [MAX_W:0] s;
    s = $signed({p.a[MAX_W-1], p.a}) + $signed({p.b[MAX_W-1], p.b});
    if (s > sat_max(OUT_WIDTH))
      return {1'b1, OUT_WIDTH'(sat_max(OUT_WIDTH))};
    else if (s < sat_min(OUT_WIDTH))
      return {1'b1, OUT_WIDTH'(sat_min(OUT_WIDTH))};
    else
      return {1'b0, s[OUT_WIDTH-1:0]};
  endfunction

  always_comb {sat_d, sum_d} = sat_sum(pay_p1);
  assign rsp_sat = sat_p2;
`else
  assign sum_d   = wrap_sum(pay_p1);
  assign rsp_sat = 1'b0;
`endif

  assign s2_adv = !vld_p2 || rsp_ready;
  assign s1_adv = !vld_p1 || s2_adv;

  // Gating with reset_n keeps req_ready low while the block is held in reset.
  rr_arbiter #(
    .N_REQ    (N_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_arbiter (
    .req       (req_valid),
    .en        (s1_adv && reset_n),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign rr_next   = (grant_idx == ID_WIDTH'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
  assign a_sel     = req_a[int'(grant_idx)*IN1_WIDTH +: IN1_WIDTH];
  assign b_sel     = req_b[int'(grant_idx)*IN2_WIDTH +: IN2_WIDTH];

  // ---- stage 1: arbitration and operand capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1 <= 1'b0;
      rr_ptr <= '0;
      pay_p1 <= '0;
      id_p1  <= '0;
    end else if (s1_adv) begin
      vld_p1 <= |grant;
      if (|grant) begin
        pay_p1.a <= MAX_W'(a_sel);
        pay_p1.b <= MAX_W'(b_sel);
        id_p1    <= grant_idx;
        rr_ptr   <= rr_next;
      end
    end
  end

  // ---- stage 2: sum and response register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p2 <= 1'b0;
      id_p2  <= '0;
      sum_p2 <= '0;
`ifdef PSUM_SAT_EN
      sat_p2 <= 1'b0;
`endif
    end else if (s2_adv) begin
      vld_p2 <= vld_p1;
      id_p2  <= id_p1;
      sum_p2 <= sum_d;
`ifdef PSUM_SAT_EN
      sat_p2 <= sat_d;
`endif
    end
  end

  assign rsp_valid = vld_p2;
  assign rsp_id    = id_p2;
  assign rsp_sum   = sum_p2;
  assign busy      = vld_p1 || vld_p2;

endmodule
